btn_event_decoder: RTL and testbench

Conditions the raw user push-button input into clean, debounced press events for the rest of the design. It synchronises the asynchronous pad and rejects contact bounce. It emits single-cycle press, short-release, long-hold and release strobes, plus a debounced level. It sits on the input side beside the LED drivers and reset controller, so top-level logic never samples the button pad directly.

---
 rtl/btn_event_decoder.sv | 137 +++++++++++++
 tb/tb_btn_event_decoder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - push-button synchroniser, debouncer and press/short/long/release event decoder
module btn_event_decoder #(
   parameter int DEBOUNCE_CYCLES = 48000,
   parameter int LONG_CYCLES     = 48000000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic release_pulse
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic IDLE_PAD = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   logic              sync1;
   logic              sync2;
   logic              s;
   logic              db_level;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_next;
   state_t            state;
   state_t            state_next;
   logic              rise;
   logic              fall;
   logic              press_next;
   logic              short_next;
   logic              long_next;
   logic              release_next;

   // Two-flop synchroniser on the asynchronous pad, parked at the not-pressed level in reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= IDLE_PAD;
         sync2 <= IDLE_PAD;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         db_level <= 1'b0;
         db_cnt   <= '0;
      end else if (s == db_level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         db_level <= s;
         db_cnt   <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // btn_level lags db_level by one cycle so it moves on the same edge as the strobes
   assign rise = db_level & ~btn_level;
   assign fall = ~db_level & btn_level;

   // Next-state and strobe decode; a release in the threshold cycle beats the long event
   always_comb begin
      state_next   = state;
      hold_next    = hold_cnt;
      press_next   = 1'b0;
      short_next   = 1'b0;
      long_next    = 1'b0;
      release_next = 1'b0;
      case (state)
         IDLE: begin
            hold_next = '0;
            if (rise) begin
               press_next = 1'b1;
               state_next = PRESSED;
            end
         end
         PRESSED: begin
            hold_next = hold_cnt + 1'b1;
            if (fall) begin
               short_next   = 1'b1;
               release_next = 1'b1;
               state_next   = IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               long_next  = 1'b1;
               state_next = LONG;
            end
         end
         LONG: begin
            if (fall) begin
               release_next = 1'b1;
               state_next   = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, hold counter, level and registered single-cycle strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_next;
         hold_cnt      <= hold_next;
         btn_level     <= db_level;
         press_pulse   <= press_next;
         short_pulse   <= short_next;
         long_pulse    <= long_next;
         release_pulse <= release_next;
      end
   end

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - self-checking bench for btn_event_decoder
module tb_btn_event_decoder;

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic short_pulse;
   logic long_pulse;
   logic release_pulse;

   int checks   = 0;
   int failures = 0;

   // expected {btn_level, press, short, long, release} per edge
   logic [4:0] exp_q[$];

   typedef struct {
      string name;
      int    low_len;
      int    total;
      int    p;
      int    s;
      int    l;
      int    r;
      int    lvl_lo;
      int    lvl_hi;
   } vec_t;

   vec_t vecs[3];

   btn_event_decoder #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES(20),
      .ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .btn_level(btn_level),
      .press_pulse(press_pulse),
      .short_pulse(short_pulse),
      .long_pulse(long_pulse),
      .release_pulse(release_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] mk_exp(int k, int p, int s, int l, int r, int lo, int hi);
      mk_exp = {(k >= lo && k <= hi), (k == p), (k == s), (k == l), (k == r)};
   endfunction

   // Drive inputs away from the edge, queue the expectation, then pop and compare after the edge
   task automatic step(input string name, input int k, input logic rst_v, input logic btn_v,
                       input logic [4:0] exp_v);
      logic [4:0] want;
      logic [4:0] got;
      rst    = rst_v;
      btn_in = btn_v;
      exp_q.push_back(exp_v);
      @(posedge clk);
      #1;
      got  = {btn_level, press_pulse, short_pulse, long_pulse, release_pulse};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cycle %0d: got lvl/press/short/long/rel=%b required=%b", name, k, got, want);
      end
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{"short_press", 10, 25, 6, 16, -1, 16, 6, 15};
      vecs[1] = '{"long_press",  40, 55, 6, -1, 26, 46, 6, 45};
      vecs[2] = '{"coincidence", 20, 35, 6, 26, -1, 26, 6, 25};

      rst    = 1'b1;
      btn_in = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 3; k++) step("reset", k, 1'b1, 1'b1, 5'b0);
      for (int k = 0; k < 100; k++) step("reset_idle", k, 1'b0, 1'b1, 5'b0);

      for (int v = 0; v < 3; v++) begin
         for (int k = 0; k < vecs[v].total; k++) begin
            step(vecs[v].name, k, 1'b0, (k < vecs[v].low_len) ? 1'b0 : 1'b1,
                 mk_exp(k, vecs[v].p, vecs[v].s, vecs[v].l, vecs[v].r, vecs[v].lvl_lo, vecs[v].lvl_hi));
         end
      end

      // bounce: runs of 2 samples never reach the debounce threshold
      for (int k = 0; k < 30; k++) step("bounce", k, 1'b0, ((k / 2) % 2) != 0, 5'b0);
      for (int k = 30; k < 45; k++) step("bounce_tail", k, 1'b0, 1'b1, 5'b0);

      // reset mid-hold: long reached, reset at cycle 30, held button is a new press
      for (int k = 0; k < 30; k++)
         step("mid_reset_pre", k, 1'b0, 1'b0, mk_exp(k, 6, -1, 26, -1, 6, 29));
      step("mid_reset_edge", 30, 1'b1, 1'b0, 5'b0);
      for (int k = 31; k < 60; k++)
         step("mid_reset_post", k, 1'b0, (k < 45) ? 1'b0 : 1'b1,
              mk_exp(k, 37, 51, -1, 51, 37, 50));

      for (int k = 0; k < 10; k++) step("final_idle", k, 1'b0, 1'b1, 5'b0);

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion required completion within budget");
      $fatal(1, "timeout");
   end

endmodule
